// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: guaranteed VGA prefetch slots, writer gets the rest.
// Optional macro FB_ARB_VBLANK_WR_EN restricts writer transfers to vertical blanking.
module vga_fb_arbiter #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned ADDR_W    = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              pixel_out,
  output logic              pixel_valid
);

  localparam int unsigned       WORDS_PER_LINE = H_DISPLAY / 16;
  localparam logic [9:0]        H_PRELOAD      = 10'(H_TOTAL - 3);
  localparam logic [9:0]        H_SLOT_END     = 10'(H_DISPLAY - 16);
  localparam logic [9:0]        H_VIS          = 10'(H_DISPLAY);
  localparam logic [9:0]        V_VIS          = 10'(V_DISPLAY);
  localparam logic [9:0]        V_LAST         = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] FB_WORDS       = ADDR_W'(WORDS_PER_LINE * V_DISPLAY);

  localparam logic [1:0] OWN_IDLE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_WRITE = 2'd2;

  logic              preload_slot, inline_slot, slot_used, xfer;
  logic [9:0]        tgt_line, tgt_col;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        owner_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic              fetch_p1_q, fetch_p2_q;
  logic [15:0]       pbuf_q, pbuf_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              pix_q, pix_d;
  logic              pvalid_q, pvalid_d;
  logic              armed_q, armed_d;
  logic              vis, cur_bit;

  always_comb begin
    preload_slot = (h_count == H_PRELOAD);
    inline_slot  = (h_count < H_SLOT_END) && (h_count[3:0] == 4'd13);
    if (preload_slot) begin
      tgt_line = (v_count == V_LAST) ? '0 : v_count + 10'd1;
      tgt_col  = '0;
    end else begin
      tgt_line = v_count;
      tgt_col  = (h_count + 10'd3) >> 4;
    end
    slot_used  = (preload_slot || inline_slot) && (tgt_line < V_VIS);
    fetch_addr = ADDR_W'(32'(tgt_line) * WORDS_PER_LINE + 32'(tgt_col));
  end

`ifdef FB_ARB_VBLANK_WR_EN
  assign wr_ready = !slot_used && !reset && (v_count >= V_VIS);
`else
  assign wr_ready = !slot_used && !reset;
`endif

  assign xfer = wr_valid && wr_ready;

  always_comb begin
    owner_d = OWN_IDLE;
    if (slot_used)                         owner_d = OWN_FETCH;
    else if (xfer && (wr_addr < FB_WORDS)) owner_d = OWN_WRITE;

    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    case (owner_d)
      OWN_FETCH: mem_addr_d = fetch_addr;
      OWN_WRITE: begin
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_data;
        mem_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // The prefetch word lands at h%16==15 and is consumed at h%16==0, so buffer
  // and shift register never contend within a word.
  always_comb begin
    pbuf_d  = fetch_p2_q ? mem_rdata : pbuf_q;
    vis     = (h_count < H_VIS) && (v_count < V_VIS);
    if (h_count[3:0] == 4'd0) begin
      cur_bit = pbuf_q[15];
      shreg_d = {pbuf_q[14:0], 1'b0};
    end else begin
      cur_bit = shreg_q[15];
      shreg_d = {shreg_q[14:0], 1'b0};
    end
    pix_d    = vis && armed_q && cur_bit;
    pvalid_d = vis;
    armed_d  = armed_q || preload_slot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      fetch_p1_q  <= 1'b0;
      fetch_p2_q  <= 1'b0;
      pbuf_q      <= '0;
      shreg_q     <= '0;
      pix_q       <= 1'b0;
      pvalid_q    <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      fetch_p1_q  <= (owner_d == OWN_FETCH);
      fetch_p2_q  <= fetch_p1_q;
      pbuf_q      <= pbuf_d;
      shreg_q     <= shreg_d;
      pix_q       <= pix_d;
      pvalid_q    <= pvalid_d;
      armed_q     <= armed_d;
    end
  end

  // Outputs forced low while reset is high so a transfer accepted just before
  // reset never reaches the RAM.
  assign mem_addr    = reset ? '0 : mem_addr_q;
  assign mem_we      = mem_we_q && !reset;
  assign mem_wdata   = reset ? '0 : mem_wdata_q;
  assign pixel_out   = pix_q && !reset;
  assign pixel_valid = pvalid_q && !reset;

endmodule
